// File: rtl/spi_fb_writer.sv
// -----------------------------------------------------------------------------
// spi_fb_writer
//
// Turns a stream of 32-bit SPI words into writes to a double-buffered
// framebuffer. The first word after chip-select fall is a header
// (opcode in [31:24], argument in [23:0]); the words after it are
// handled according to that header:
//   0x01 : set the write pointer, then every data word is one RGB888 pixel
//          written into the back bank, with the pointer advancing and wrapping
//   0x02 : request a bank swap, performed on the next frame_end
//   0x03 : set global brightness from argument[7:0]
//   other: unknown opcode, counted as a dropped word
// Data words that arrive while no pixel transaction is open are dropped and
// counted in a saturating 8-bit counter.
//
// Ports
//   clk         sole clock, rising edge
//   resetn      synchronous active-low reset
//   read_value  received SPI word (valid with done)
//   first_word  marks read_value as a header (valid with done)
//   done        one-cycle word-valid strobe
//   frame_end   one-cycle end-of-displayed-frame pulse from the scanner
//   fb_we       framebuffer write strobe (one cycle per pixel)
//   fb_waddr    {bank, pixel address}; bank is always the back bank
//   fb_wdata    RGB888 pixel
//   disp_bank   bank currently shown by the scanner
//   brightness  global brightness level
//   drop_count  saturating count of discarded words
// -----------------------------------------------------------------------------
module spi_fb_writer #(
    parameter int ADDR_BITS = 12,
    parameter int NPIXELS   = 4096
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          read_value,
    input  logic                 first_word,
    input  logic                 done,
    input  logic                 frame_end,
    output logic                 fb_we,
    output logic [ADDR_BITS:0]   fb_waddr,
    output logic [23:0]          fb_wdata,
    output logic                 disp_bank,
    output logic [7:0]           brightness,
    output logic [7:0]           drop_count
);

    // Pixel count widened by one bit so NPIXELS == 2**ADDR_BITS is representable.
    localparam logic [ADDR_BITS:0]   NPIX_W    = (ADDR_BITS+1)'(NPIXELS);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIXELS - 1);

    localparam logic [7:0] OP_SET_ADDR   = 8'h01;
    localparam logic [7:0] OP_SWAP       = 8'h02;
    localparam logic [7:0] OP_BRIGHTNESS = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PIXELS  = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   ptr_reg, ptr_next;
    logic                   fb_we_reg, fb_we_next;
    logic [ADDR_BITS:0]     fb_waddr_reg, fb_waddr_next;
    logic [23:0]            fb_wdata_reg, fb_wdata_next;
    logic                   disp_bank_reg, disp_bank_next;
    logic                   swap_pending_reg, swap_pending_next;
    logic [7:0]             brightness_reg, brightness_next;
    logic [7:0]             drop_count_reg, drop_count_next;

    logic                   is_header;
    logic                   is_data;
    logic [7:0]             opcode;
    logic [23:0]            argument;
    logic [ADDR_BITS-1:0]   start_addr;
    logic                   drop_inc;

    assign is_header  = done & first_word;
    assign is_data    = done & ~first_word;
    assign opcode     = read_value[31:24];
    assign argument   = read_value[23:0];
    assign start_addr = argument[ADDR_BITS-1:0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: a header always restarts the transaction, whatever
    // state we are in; only the set-address opcode opens a pixel stream.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (is_header) begin
            if (opcode == OP_SET_ADDR) begin
                state_next = ST_PIXELS;
            end else begin
                state_next = ST_DISCARD;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        ptr_next          = ptr_reg;
        fb_we_next        = 1'b0;
        fb_waddr_next     = fb_waddr_reg;
        fb_wdata_next     = fb_wdata_reg;
        disp_bank_next    = disp_bank_reg;
        swap_pending_next = swap_pending_reg;
        brightness_next   = brightness_reg;
        drop_count_next   = drop_count_reg;
        drop_inc          = 1'b0;

        if (is_header) begin
            case (opcode)
                OP_SET_ADDR: begin
                    // Out-of-range start addresses restart at pixel 0.
                    if ({1'b0, start_addr} >= NPIX_W) begin
                        ptr_next = '0;
                    end else begin
                        ptr_next = start_addr;
                    end
                end
                OP_SWAP: begin
                    // Re-requesting while pending leaves the single request in place.
                    swap_pending_next = 1'b1;
                end
                OP_BRIGHTNESS: begin
                    brightness_next = argument[7:0];
                end
                default: begin
                    drop_inc = 1'b1;
                end
            endcase
        end else if (is_data) begin
            if (state_reg == ST_PIXELS) begin
                fb_we_next    = 1'b1;
                fb_wdata_next = argument;
                // Target is always the bank not being displayed right now, so a
                // swap in the middle of a stream redirects later pixels only.
                fb_waddr_next = {~disp_bank_reg, ptr_reg};
                if (ptr_reg == LAST_ADDR) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end else begin
                drop_inc = 1'b1;
            end
        end

        // Only a request that was already pending before this cycle is served,
        // so a swap header coinciding with frame_end waits for the next frame.
        if (swap_pending_reg && frame_end) begin
            disp_bank_next    = ~disp_bank_reg;
            swap_pending_next = 1'b0;
        end

        if (drop_inc && (drop_count_reg != 8'hFF)) begin
            drop_count_next = drop_count_reg + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_reg          <= '0;
            fb_we_reg        <= 1'b0;
            fb_waddr_reg     <= '0;
            fb_wdata_reg     <= '0;
            disp_bank_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
            brightness_reg   <= 8'h80;
            drop_count_reg   <= 8'h00;
        end else begin
            ptr_reg          <= ptr_next;
            fb_we_reg        <= fb_we_next;
            fb_waddr_reg     <= fb_waddr_next;
            fb_wdata_reg     <= fb_wdata_next;
            disp_bank_reg    <= disp_bank_next;
            swap_pending_reg <= swap_pending_next;
            brightness_reg   <= brightness_next;
            drop_count_reg   <= drop_count_next;
        end
    end

    assign fb_we      = fb_we_reg;
    assign fb_waddr   = fb_waddr_reg;
    assign fb_wdata   = fb_wdata_reg;
    assign disp_bank  = disp_bank_reg;
    assign brightness = brightness_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_spi_fb_writer.sv
// -----------------------------------------------------------------------------
// tb_spi_fb_writer
//
// Directed bench for spi_fb_writer: pixel streaming, address wrap, bank swap
// timing, brightness, unknown opcodes, drop counter saturation and reset in
// the middle of a pixel stream. Inputs change on the falling edge, outputs are
// checked on the falling edge after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_spi_fb_writer;

    localparam int ADDR_BITS = 12;
    localparam int NPIXELS   = 4096;

    logic                 clk;
    logic                 resetn;
    logic [31:0]          read_value;
    logic                 first_word;
    logic                 done;
    logic                 frame_end;
    logic                 fb_we;
    logic [ADDR_BITS:0]   fb_waddr;
    logic [23:0]          fb_wdata;
    logic                 disp_bank;
    logic [7:0]           brightness;
    logic [7:0]           drop_count;

    int checks;
    int errors;

    spi_fb_writer #(
        .ADDR_BITS (ADDR_BITS),
        .NPIXELS   (NPIXELS)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .read_value (read_value),
        .first_word (first_word),
        .done       (done),
        .frame_end  (frame_end),
        .fb_we      (fb_we),
        .fb_waddr   (fb_waddr),
        .fb_wdata   (fb_wdata),
        .disp_bank  (disp_bank),
        .brightness (brightness),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word for a single cycle; returns on the falling edge right
    // after the rising edge that consumed it, i.e. where a 1-cycle write shows.
    task automatic send_word(input logic [31:0] word, input logic hdr, input logic fe);
        @(negedge clk);
        read_value = word;
        first_word = hdr;
        done       = 1'b1;
        frame_end  = fe;
        @(negedge clk);
        done       = 1'b0;
        first_word = 1'b0;
        frame_end  = 1'b0;
        $display("tx %s 0x%08h fe=%0d -> we=%0d addr=0x%0h data=0x%0h bank=%0d drop=%0d",
                 hdr ? "hdr " : "data", word, fe, fb_we, fb_waddr, fb_wdata, disp_bank, drop_count);
    endtask

    // One-cycle frame_end pulse; returns on the falling edge one cycle later.
    task automatic pulse_frame_end();
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        $display("tx frame_end -> bank=%0d", disp_bank);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        $display("tx reset");
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_we"},     32'(fb_we),      32'h0);
        check({pfx, "_waddr"},  32'(fb_waddr),   32'h0);
        check({pfx, "_wdata"},  32'(fb_wdata),   32'h0);
        check({pfx, "_bank"},   32'(disp_bank),  32'h0);
        check({pfx, "_bright"}, 32'(brightness), 32'h80);
        check({pfx, "_drop"},   32'(drop_count), 32'h0);
    endtask

    initial begin
        logic we_seen;

        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        read_value = '0;
        first_word = 1'b0;
        done       = 1'b0;
        frame_end  = 1'b0;

        do_reset();
        check_reset_values("rst");

        // Pixel stream from 0x010, back bank is 1 while displaying 0.
        send_word(32'h01000010, 1'b1, 1'b0);
        check("hdr_no_we", 32'(fb_we), 32'h0);
        send_word(32'h00FF0000, 1'b0, 1'b0);
        check("px0_we",    32'(fb_we),    32'h1);
        check("px0_addr",  32'(fb_waddr), 32'h1010);
        check("px0_data",  32'(fb_wdata), 32'hFF0000);
        send_word(32'h0000FF00, 1'b0, 1'b0);
        check("px1_we",    32'(fb_we),    32'h1);
        check("px1_addr",  32'(fb_waddr), 32'h1011);
        check("px1_data",  32'(fb_wdata), 32'h00FF00);
        @(negedge clk);
        check("px_pulse_end", 32'(fb_we),    32'h0);
        check("px_hold_addr", 32'(fb_waddr), 32'h1011);
        check("px_hold_data", 32'(fb_wdata), 32'h00FF00);

        // Pointer wrap at the last pixel.
        send_word(32'h01000FFF, 1'b1, 1'b0);
        send_word(32'h00000001, 1'b0, 1'b0);
        check("wrap0_addr", 32'(fb_waddr), 32'h1FFF);
        send_word(32'h00000002, 1'b0, 1'b0);
        check("wrap1_addr", 32'(fb_waddr), 32'h1000);
        send_word(32'h00000003, 1'b0, 1'b0);
        check("wrap2_addr", 32'(fb_waddr), 32'h1001);
        check("wrap2_data", 32'(fb_wdata), 32'h000003);

        // Swap request: one toggle, one cycle after the first frame_end.
        send_word(32'h02000000, 1'b1, 1'b0);
        check("swap_wait", 32'(disp_bank), 32'h0);
        pulse_frame_end();
        check("swap_done", 32'(disp_bank), 32'h1);
        pulse_frame_end();
        check("swap_once", 32'(disp_bank), 32'h1);
        send_word(32'h01000000, 1'b1, 1'b0);
        send_word(32'h00123456, 1'b0, 1'b0);
        check("swap_px_addr", 32'(fb_waddr), 32'h0000);
        check("swap_px_data", 32'(fb_wdata), 32'h123456);

        // Swap that lands in the middle of a pixel stream.
        send_word(32'h02000000, 1'b1, 1'b0);
        send_word(32'h01000020, 1'b1, 1'b0);
        send_word(32'h00AAAAAA, 1'b0, 1'b0);
        check("mid_px0_addr", 32'(fb_waddr), 32'h0020);
        pulse_frame_end();
        check("mid_bank", 32'(disp_bank), 32'h0);
        send_word(32'h00BBBBBB, 1'b0, 1'b0);
        check("mid_px1_we",   32'(fb_we),    32'h1);
        check("mid_px1_addr", 32'(fb_waddr), 32'h1021);

        // Swap header coinciding with frame_end waits for the next frame.
        send_word(32'h02000000, 1'b1, 1'b1);
        check("same_cyc_bank", 32'(disp_bank), 32'h0);
        pulse_frame_end();
        check("same_cyc_swap", 32'(disp_bank), 32'h1);

        // Two swap headers still give a single toggle.
        send_word(32'h02000000, 1'b1, 1'b0);
        send_word(32'h02000000, 1'b1, 1'b0);
        pulse_frame_end();
        check("dbl_swap0", 32'(disp_bank), 32'h0);
        pulse_frame_end();
        check("dbl_swap1", 32'(disp_bank), 32'h0);
        check("drop_none", 32'(drop_count), 32'h0);

        // Brightness, then data words that get discarded.
        send_word(32'h03000040, 1'b1, 1'b0);
        check("bright", 32'(brightness), 32'h40);
        for (int i = 1; i <= 3; i++) begin
            send_word(32'h00ABCDEF, 1'b0, 1'b0);
            check($sformatf("disc%0d_we", i),   32'(fb_we),      32'h0);
            check($sformatf("disc%0d_drop", i), 32'(drop_count), 32'(i));
        end

        // Unknown opcode counts once, following data counts too.
        send_word(32'h7F000000, 1'b1, 1'b0);
        check("unk_drop", 32'(drop_count), 32'h4);
        send_word(32'h00000000, 1'b0, 1'b0);
        check("unk_data_drop", 32'(drop_count), 32'h5);
        check("unk_data_we",   32'(fb_we),      32'h0);

        // 300 headerless data words after reset: saturation at 255.
        do_reset();
        we_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            read_value = 32'(i);
            done       = 1'b1;
            @(negedge clk);
            done = 1'b0;
            if (fb_we) we_seen = 1'b1;
        end
        $display("tx 300 headerless data words -> drop=%0d", drop_count);
        check("sat_we_seen", 32'(we_seen),    32'h0);
        check("sat_drop",    32'(drop_count), 32'hFF);

        // Reset arriving together with a data word in the middle of a stream.
        do_reset();
        send_word(32'h01000005, 1'b1, 1'b0);
        send_word(32'h00112233, 1'b0, 1'b0);
        check("pre_rst_we",   32'(fb_we),    32'h1);
        check("pre_rst_addr", 32'(fb_waddr), 32'h1005);
        @(negedge clk);
        resetn     = 1'b0;
        read_value = 32'h00445566;
        done       = 1'b1;
        frame_end  = 1'b1;
        @(negedge clk);
        done      = 1'b0;
        frame_end = 1'b0;
        resetn    = 1'b1;
        $display("tx reset with done and frame_end");
        check_reset_values("cut");
        send_word(32'h00778899, 1'b0, 1'b0);
        check("cut_d0_we",    32'(fb_we),      32'h0);
        send_word(32'h00AABBCC, 1'b0, 1'b0);
        check("cut_d1_we",    32'(fb_we),      32'h0);
        check("cut_d1_waddr", 32'(fb_waddr),   32'h0);
        check("cut_d1_wdata", 32'(fb_wdata),   32'h0);
        check("cut_d1_bank",  32'(disp_bank),  32'h0);
        check("cut_d1_drop",  32'(drop_count), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
